// File: rtl/data_ram_if.sv
// MEM-stage load/store bus between the pipeline (master) and the data RAM responder (slave).
// Signal suffixes are from the responder's point of view.
interface data_ram_if;
   logic        ce_i;
   logic        we_i;
   logic [31:0] addr_i;
   logic [3:0]  sel_i;
   logic [31:0] data_i;
   logic [31:0] data_o;
   logic        stall_req_o;
   logic        ack_o;
   logic        err_o;

   modport master (
      output ce_i, we_i, addr_i, sel_i, data_i,
      input  data_o, stall_req_o, ack_o, err_o
   );

   modport slave (
      input  ce_i, we_i, addr_i, sel_i, data_i,
      output data_o, stall_req_o, ack_o, err_o
   );
endinterface

// File: rtl/data_ram_responder.sv
// Data-side RAM responder: latches a MEM-stage request, waits WAIT_CYCLES, accesses a big-endian
// word array and acks for one cycle. Optional bounds check: DATA_RAM_BOUNDS_CHECK_EN.
module data_ram_responder #(
   parameter int unsigned DEPTH       = 1024,
   parameter int unsigned AW          = 10,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input logic       clk,
   input logic       rst,
   data_ram_if.slave bus
);

   typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

   state_e          state_q;
   logic [3:0]      cnt_q;
   logic            we_q;
   logic [AW-1:0]   idx_q;
   logic [3:0]      sel_q;
   logic [31:0]     wdata_q;
   logic            oob_q;
   logic [31:0]     rdata_q;
   logic            ack_q;
   logic            err_q;

   logic [31:0]     mem [DEPTH];

   logic            req_oob;
   logic            access_go;
   logic            mem_we;
   logic            unused_addr;

`ifdef DATA_RAM_BOUNDS_CHECK_EN
   assign req_oob     = |bus.addr_i[31:AW+2];
   assign unused_addr = ^bus.addr_i[1:0];
`else
   // Upper address bits are ignored, so addresses alias modulo DEPTH*4.
   assign req_oob     = 1'b0;
   assign unused_addr = ^{bus.addr_i[31:AW+2], bus.addr_i[1:0]};
`endif

   assign access_go = (state_q == StAccess) && (cnt_q == 4'd0);
   assign mem_we    = access_go && we_q && !oob_q && !rst;

   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int i = 0; i < 4; i++) begin
            if (sel_q[i]) mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= 4'd0;
         we_q    <= 1'b0;
         idx_q   <= '0;
         sel_q   <= 4'd0;
         wdata_q <= 32'd0;
         oob_q   <= 1'b0;
         rdata_q <= 32'd0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         ack_q <= 1'b0;
         err_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (bus.ce_i) begin
                  we_q    <= bus.we_i;
                  idx_q   <= bus.addr_i[AW+1:2];
                  sel_q   <= bus.sel_i;
                  wdata_q <= bus.data_i;
                  oob_q   <= req_oob;
                  cnt_q   <= 4'(WAIT_CYCLES);
                  state_q <= StAccess;
               end
            end
            StAccess: begin
               if (cnt_q != 4'd0) begin
                  cnt_q <= cnt_q - 4'd1;
               end else begin
                  // Out-of-range accesses force data_o to 0 even for writes.
                  if (oob_q)      rdata_q <= 32'd0;
                  else if (!we_q) rdata_q <= mem[idx_q];
                  ack_q   <= 1'b1;
                  err_q   <= oob_q;
                  state_q <= StResp;
               end
            end
            StResp:  state_q <= StIdle;
            default: state_q <= StIdle;
         endcase
      end
   end

   // Drops in RESP so the MEM stage captures data_o and advances at the end of RESP.
   assign bus.stall_req_o = bus.ce_i && (state_q != StResp);
   assign bus.data_o      = rdata_q;
   assign bus.ack_o       = ack_q;
   assign bus.err_o       = err_q;

endmodule
